// File: rtl/usystolic_pkg.sv
// Shared types and constants for the unary systolic GEMM array control path.
package usystolic_pkg;

  localparam int M_END_BITWIDTH = 2;

  localparam logic [M_END_BITWIDTH-1:0] M_END_HOLD  = 2'b00;
  localparam logic [M_END_BITWIDTH-1:0] M_END_MAC   = 2'b01;
  localparam logic [M_END_BITWIDTH-1:0] M_END_DRAIN = 2'b10;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_LOAD_W,
    SEQ_COMPUTE,
    SEQ_DRAIN,
    SEQ_DONE
  } seq_state_t;

endpackage

// File: rtl/seq_phase_counter.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module seq_phase_counter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (!zero) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Tile sequencer: LOAD_W -> COMPUTE -> DRAIN -> DONE, outputs decoded from state.
// Optional SEQ_EARLY_TERM_EN adds a runtime stream length sampled at start.
module systolic_seq_ctrl
  import usystolic_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int STREAM_LEN = 128
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
`ifdef SEQ_EARLY_TERM_EN
  input  logic [$clog2(STREAM_LEN+1)-1:0]     cfg_stream_len,
`endif
  output logic                                busy,
  output logic                                done,
  output logic                                out_clear,
  output logic                                weight_reg_en,
  output logic                                weight_reg_r0w1,
  output logic                                input_reg_en,
  output logic                                input_reg_r0w1,
  output logic                                rand_num_reg_en,
  output logic                                rand_num_reg_r0w1,
  output logic                                output_num_reg_en,
  output logic                                output_num_reg_r0w1,
  output logic [M_END_BITWIDTH-1:0]           M_end,
  output logic                                rng_en
);

  localparam int CW = $clog2(STREAM_LEN + ROWS + COLS);
  localparam int LW = $clog2(STREAM_LEN + 1);

  seq_state_t      state, state_next;
  logic            cnt_load;
  logic [CW-1:0]   cnt_load_val;
  logic [CW-1:0]   cnt;
  logic            cnt_zero;
  logic [LW-1:0]   len_q;

`ifdef SEQ_EARLY_TERM_EN
  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] v);
    if (v == '0 || int'(v) > STREAM_LEN) return LW'(STREAM_LEN);
    return v;
  endfunction

  // Latched once per tile so mid-tile changes of the port are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q <= LW'(STREAM_LEN);
    end else if (state == SEQ_IDLE && start) begin
      len_q <= sat_len(cfg_stream_len);
    end
  end
`else
  assign len_q = LW'(STREAM_LEN);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      SEQ_IDLE:    if (start)    state_next = SEQ_LOAD_W;
      SEQ_LOAD_W:  if (cnt_zero) state_next = SEQ_COMPUTE;
      SEQ_COMPUTE: if (cnt_zero) state_next = SEQ_DRAIN;
      SEQ_DRAIN:   if (cnt_zero) state_next = SEQ_DONE;
      SEQ_DONE:                  state_next = SEQ_IDLE;
      default:                   state_next = SEQ_IDLE;
    endcase
    if (abort && state != SEQ_IDLE) state_next = SEQ_IDLE;
  end

  // Counter is reloaded with (phase length - 1) on every state change.
  always_comb begin
    cnt_load     = (state_next != state);
    cnt_load_val = '0;
    case (state_next)
      SEQ_LOAD_W:  cnt_load_val = CW'(ROWS - 1);
      SEQ_COMPUTE: cnt_load_val = CW'(int'(len_q) + ROWS + COLS - 3);
      SEQ_DRAIN:   cnt_load_val = CW'(ROWS - 1);
      default:     cnt_load_val = '0;
    endcase
  end

  seq_phase_counter #(.WIDTH(CW)) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    busy              = (state != SEQ_IDLE);
    done              = 1'b0;
    out_clear         = 1'b0;
    weight_reg_en     = 1'b0;
    input_reg_en      = 1'b0;
    rand_num_reg_en   = 1'b0;
    output_num_reg_en = 1'b0;
    rng_en            = 1'b0;
    M_end             = M_END_HOLD;
    case (state)
      SEQ_LOAD_W: begin
        weight_reg_en = 1'b1;
        out_clear     = (cnt == CW'(ROWS - 1));
      end
      SEQ_COMPUTE: begin
        input_reg_en      = 1'b1;
        rand_num_reg_en   = 1'b1;
        output_num_reg_en = 1'b1;
        rng_en            = 1'b1;
        M_end             = M_END_MAC;
      end
      SEQ_DRAIN: begin
        output_num_reg_en = 1'b1;
        M_end             = M_END_DRAIN;
      end
      SEQ_DONE: done = 1'b1;
      default: ;
    endcase
    weight_reg_r0w1     = weight_reg_en;
    input_reg_r0w1      = input_reg_en;
    rand_num_reg_r0w1   = rand_num_reg_en;
    output_num_reg_r0w1 = output_num_reg_en;
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl (ROWS=4, COLS=4, STREAM_LEN=16).
module tb_systolic_seq_ctrl;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int STREAM_LEN = 16;
  localparam int LW         = $clog2(STREAM_LEN + 1);

  localparam logic [13:0] V_IDLE  = 14'h0000;
  localparam logic [13:0] V_LOAD1 = 14'h2E00;
  localparam logic [13:0] V_LOAD  = 14'h2600;
  localparam logic [13:0] V_COMP  = 14'h21FB;
  localparam logic [13:0] V_DRAIN = 14'h201C;
  localparam logic [13:0] V_DONE  = 14'h3000;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [LW-1:0] cfg;
  logic          busy, done, out_clear;
  logic          w_en, w_rw, i_en, i_rw, r_en, r_rw, o_en, o_rw, rng_en;
  logic [1:0]    m_end;
  logic [13:0]   vec;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.ROWS(ROWS), .COLS(COLS), .STREAM_LEN(STREAM_LEN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .abort               (abort),
`ifdef SEQ_EARLY_TERM_EN
    .cfg_stream_len      (cfg),
`endif
    .busy                (busy),
    .done                (done),
    .out_clear           (out_clear),
    .weight_reg_en       (w_en),
    .weight_reg_r0w1     (w_rw),
    .input_reg_en        (i_en),
    .input_reg_r0w1      (i_rw),
    .rand_num_reg_en     (r_en),
    .rand_num_reg_r0w1   (r_rw),
    .output_num_reg_en   (o_en),
    .output_num_reg_r0w1 (o_rw),
    .M_end               (m_end),
    .rng_en              (rng_en)
  );

  assign vec = {busy, done, out_clear, w_en, w_rw, i_en, i_rw, r_en, r_rw,
                o_en, o_rw, m_end, rng_en};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected output vector i cycles after start was sampled, stream length l.
  function automatic logic [13:0] exp_vec(input int i, input int l);
    int comp_end;
    comp_end = ROWS + l + ROWS + COLS - 2;
    if (i < 1)                    return V_IDLE;
    if (i == 1)                   return V_LOAD1;
    if (i <= ROWS)                return V_LOAD;
    if (i <= comp_end)            return V_COMP;
    if (i <= comp_end + ROWS)     return V_DRAIN;
    if (i == comp_end + ROWS + 1) return V_DONE;
    return V_IDLE;
  endfunction

  task automatic run_tile(input int l, input string tag);
    int last;
    last = 2 * ROWS + l + ROWS + COLS;
    start = 1'b1;
    step();
    start = 1'b0;
`ifdef SEQ_EARLY_TERM_EN
    cfg = LW'(3);
`endif
    for (int i = 1; i <= last; i++) begin
      chk($sformatf("%s_c%0d", tag, i), 32'(vec), 32'(exp_vec(i, l)));
      if (i < last) step();
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg   = '0;
    #1;
    chk("reset_vec", 32'(vec), 32'(V_IDLE));
    step();
    step();
    rst = 1'b0;
    chk("reset_release", 32'(vec), 32'(V_IDLE));

    run_tile(STREAM_LEN, "full");

    // start pulses at 0, 10, 31 form one tile; the one at 32 starts another
    for (int c = 0; c < 63; c++) begin
      start = (c == 0 || c == 10 || c == 31 || c == 32);
      step();
      start = 1'b0;
      chk($sformatf("restart_done_c%0d", c + 1), 32'(done),
          32'((c + 1 == 31) || (c + 1 == 63)));
      chk($sformatf("restart_busy_c%0d", c + 1), 32'(busy),
          32'(((c + 1) >= 1 && (c + 1) <= 31) || ((c + 1) >= 33 && (c + 1) <= 63)));
    end
    step();
    chk("restart_idle", 32'(vec), 32'(V_IDLE));

    for (int c = 0; c < 12; c++) begin
      start = (c == 0);
      step();
      start = 1'b0;
    end
    chk("abort_pre", 32'(vec), 32'(V_COMP));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_vec", 32'(vec), 32'(V_IDLE));
    for (int c = 14; c < 40; c++) begin
      step();
      chk($sformatf("abort_nodone_c%0d", c), 32'(vec), 32'(V_IDLE));
    end

    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    chk("start_beats_abort", 32'(vec), 32'(V_LOAD1));
    step();
    abort = 1'b0;
    chk("abort_in_load", 32'(vec), 32'(V_IDLE));

    for (int c = 0; c < 20; c++) begin
      start = (c == 0);
      step();
      start = 1'b0;
    end
    chk("rst_pre", 32'(vec), 32'(V_COMP));
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async", 32'(vec), 32'(V_IDLE));
    step();
    chk("rst_hold", 32'(vec), 32'(V_IDLE));
    rst = 1'b0;
    step();
    chk("rst_after", 32'(vec), 32'(V_IDLE));
    run_tile(STREAM_LEN, "post_rst");

`ifdef SEQ_EARLY_TERM_EN
    cfg = LW'(5);
    run_tile(5, "len5");
    cfg = LW'(0);
    run_tile(STREAM_LEN, "len0");
    cfg = LW'(31);
    run_tile(STREAM_LEN, "len31");
`endif

    for (int c = 0; c < 400; c++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 15) == 0);
`ifdef SEQ_EARLY_TERM_EN
      cfg = LW'($urandom_range(0, 31));
`endif
      step();
      chk($sformatf("invariant_c%0d", c),
          32'((w_rw === w_en) && (i_rw === i_en) && (r_rw === r_en) &&
              (o_rw === o_en) && (m_end !== 2'b11) && (rng_en === i_en)),
          32'(1));
    end
    start = 1'b0;
    abort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
